// File: rtl/pdp8_uart_arb_pkg.sv
// pdp8_uart_arb_pkg: state encodings and client ids shared by the uart arbiter
package pdp8_uart_arb_pkg;
   typedef enum logic [1:0] {T_IDLE = 2'd0, T_REQ = 2'd1, T_ACK = 2'd2, T_DRAIN = 2'd3} tx_state_t;
   typedef enum logic {R_IDLE = 1'b0, R_BUSY = 1'b1} rx_state_t;
   localparam logic CL_TT  = 1'b0;
   localparam logic CL_MON = 1'b1;
endpackage

// File: rtl/pdp8_uart_arb.sv
// pdp8_uart_arb: shares one uart between the PDP-8 console (tt) and the monitor (mon)
// Tx is round-robin with a grant held for a whole character; rx follows a deferred owner select.
module pdp8_uart_arb
   import pdp8_uart_arb_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              tt_tx_req,
   input  logic [DATA_W-1:0] tt_tx_data,
   output logic              tt_tx_ack,
   output logic              tt_tx_empty,
   input  logic              mon_tx_req,
   input  logic [DATA_W-1:0] mon_tx_data,
   output logic              mon_tx_ack,
   output logic              mon_tx_empty,
   input  logic              tt_rx_req,
   input  logic              mon_rx_req,
   output logic              tt_rx_ack,
   output logic              mon_rx_ack,
   output logic              tt_rx_empty,
   output logic              mon_rx_empty,
   output logic [DATA_W-1:0] tt_rx_data,
   output logic [DATA_W-1:0] mon_rx_data,
   input  logic              rx_sel,
   output logic              uart_tx_req,
   output logic [DATA_W-1:0] uart_tx_data,
   input  logic              uart_tx_ack,
   input  logic              uart_tx_empty,
   output logic              uart_rx_req,
   input  logic              uart_rx_ack,
   input  logic              uart_rx_empty,
   input  logic [DATA_W-1:0] uart_rx_data,
   output logic              tx_owner,
   output logic              tx_busy,
   output logic              rx_owner
);
   tx_state_t         tx_state_q, tx_state_d;
   logic              grant_q, grant_d, last_q, last_d, pick;
   logic [DATA_W-1:0] tx_data_q, tx_data_d;
   rx_state_t         rx_state_q, rx_state_d;
   logic              rx_owner_q, rx_owner_d, owner_req, rx_switch;

   assign pick = (tt_tx_req & mon_tx_req) ? ~last_q : mon_tx_req;

   always_comb begin
      tx_state_d = tx_state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      tx_data_d  = tx_data_q;
      case (tx_state_q)
         T_IDLE: if (tt_tx_req | mon_tx_req) begin
            grant_d    = pick;
            tx_data_d  = (pick == CL_MON) ? mon_tx_data : tt_tx_data;
            tx_state_d = T_REQ;
         end
         T_REQ:   if (uart_tx_ack) tx_state_d = T_ACK;
         T_ACK:   if (!uart_tx_ack) tx_state_d = T_DRAIN;
         T_DRAIN: if (uart_tx_empty) begin
            last_d     = grant_q;
            tx_state_d = T_IDLE;
         end
         default: tx_state_d = T_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_state_q <= T_IDLE;
         grant_q    <= CL_TT;
         last_q     <= CL_MON;
         tx_data_q  <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign tx_busy      = tx_state_q != T_IDLE;
   assign tx_owner     = grant_q;
   assign uart_tx_req  = tx_state_q == T_REQ;
   assign uart_tx_data = tx_data_q;
   assign tt_tx_ack    = tx_busy & (grant_q == CL_TT) & uart_tx_ack;
   assign mon_tx_ack   = tx_busy & (grant_q == CL_MON) & uart_tx_ack;
   assign tt_tx_empty  = uart_tx_empty & (~tx_busy | (grant_q == CL_TT));
   assign mon_tx_empty = uart_tx_empty & (~tx_busy | (grant_q == CL_MON));

   // An owner change only takes effect from R_IDLE, and that cycle carries no request.
   assign owner_req = (rx_owner_q == CL_MON) ? mon_rx_req : tt_rx_req;
   assign rx_switch = (rx_state_q == R_IDLE) & (rx_sel != rx_owner_q);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_owner_d = rx_owner_q;
      case (rx_state_q)
         R_IDLE: if (rx_switch) rx_owner_d = rx_sel;
                 else if (owner_req) rx_state_d = R_BUSY;
         R_BUSY: if (!owner_req && !uart_rx_ack) rx_state_d = R_IDLE;
         default: rx_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state_q <= R_IDLE;
         rx_owner_q <= CL_TT;
      end else begin
         rx_state_q <= rx_state_d;
         rx_owner_q <= rx_owner_d;
      end
   end

   assign rx_owner     = rx_owner_q;
   assign uart_rx_req  = ~reset & ~rx_switch & owner_req;
   assign tt_rx_ack    = (rx_owner_q == CL_TT) & uart_rx_ack;
   assign mon_rx_ack   = (rx_owner_q == CL_MON) & uart_rx_ack;
   assign tt_rx_empty  = (rx_owner_q == CL_TT) ? uart_rx_empty : 1'b1;
   assign mon_rx_empty = (rx_owner_q == CL_MON) ? uart_rx_empty : 1'b1;
   assign tt_rx_data   = (rx_owner_q == CL_TT) ? uart_rx_data : '0;
   assign mon_rx_data  = (rx_owner_q == CL_MON) ? uart_rx_data : '0;
endmodule

// File: tb/tb_pdp8_uart_arb.sv
// tb_pdp8_uart_arb: directed checks of the tt/mon uart arbiter against a small uart tx model
module tb_pdp8_uart_arb;
   logic       clk = 0, reset = 1;
   logic       tt_tx_req = 0, mon_tx_req = 0, tt_rx_req = 0, mon_rx_req = 0, rx_sel = 0;
   logic [7:0] tt_tx_data = 0, mon_tx_data = 0, uart_rx_data = 0;
   logic       uart_rx_ack = 0, uart_rx_empty = 1;
   logic       uack = 0, uempty = 1;
   int         cnt = 0, dcnt = 0;
   logic       tt_tx_ack, tt_tx_empty, mon_tx_ack, mon_tx_empty;
   logic       tt_rx_ack, mon_rx_ack, tt_rx_empty, mon_rx_empty;
   logic [7:0] tt_rx_data, mon_rx_data, uart_tx_data;
   logic       uart_tx_req, uart_rx_req, tx_owner, tx_busy, rx_owner;
   int         total = 0, bad = 0;

   pdp8_uart_arb #(.DATA_W(8)) dut (
      .clk(clk), .reset(reset),
      .tt_tx_req(tt_tx_req), .tt_tx_data(tt_tx_data), .tt_tx_ack(tt_tx_ack), .tt_tx_empty(tt_tx_empty),
      .mon_tx_req(mon_tx_req), .mon_tx_data(mon_tx_data), .mon_tx_ack(mon_tx_ack), .mon_tx_empty(mon_tx_empty),
      .tt_rx_req(tt_rx_req), .mon_rx_req(mon_rx_req), .tt_rx_ack(tt_rx_ack), .mon_rx_ack(mon_rx_ack),
      .tt_rx_empty(tt_rx_empty), .mon_rx_empty(mon_rx_empty), .tt_rx_data(tt_rx_data), .mon_rx_data(mon_rx_data),
      .rx_sel(rx_sel),
      .uart_tx_req(uart_tx_req), .uart_tx_data(uart_tx_data), .uart_tx_ack(uack), .uart_tx_empty(uempty),
      .uart_rx_req(uart_rx_req), .uart_rx_ack(uart_rx_ack), .uart_rx_empty(uart_rx_empty), .uart_rx_data(uart_rx_data),
      .tx_owner(tx_owner), .tx_busy(tx_busy), .rx_owner(rx_owner)
   );

   always #5 clk = ~clk;

   // uart tx model: ack 2 cycles after req, ack drops with req, empty 20 cycles after ack falls
   always @(posedge clk) begin
      if (!uart_tx_req) cnt <= 0;
      if (uart_tx_req && !uack) begin
         if (cnt == 1) begin
            uack   <= 1;
            uempty <= 0;
         end else cnt <= cnt + 1;
      end else if (!uart_tx_req && uack) begin
         uack <= 0;
         dcnt <= 20;
      end else if (dcnt > 0) begin
         dcnt <= dcnt - 1;
         if (dcnt == 1) uempty <= 1;
      end
   end

   task automatic wait_req(output bit ok);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = uart_tx_req;
      end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = !tx_busy && uempty;
      end
   endtask

   task automatic wait_tt_ack(output bit ok);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = tt_tx_ack;
      end
   endtask

   task automatic test_reset();
      reset = 1;
      repeat (2) @(negedge clk);
      total += 6;
      if (tx_busy !== 0) begin bad++; $display("FAIL reset_busy got=%b want=0", tx_busy); end
      if (tx_owner !== 0) begin bad++; $display("FAIL reset_owner got=%b want=0", tx_owner); end
      if (rx_owner !== 0) begin bad++; $display("FAIL reset_rx_owner got=%b want=0", rx_owner); end
      if (uart_tx_req !== 0) begin bad++; $display("FAIL reset_tx_req got=%b want=0", uart_tx_req); end
      if (uart_tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h want=00", uart_tx_data); end
      if (tt_tx_empty !== 1 || mon_tx_empty !== 1) begin bad++; $display("FAIL reset_empty got=%b%b want=11", tt_tx_empty, mon_tx_empty); end
      reset = 0;
   endtask

   task automatic test_single();
      bit ok;
      tt_tx_data = 8'h41;
      tt_tx_req  = 1;
      @(negedge clk);
      total += 3;
      if (uart_tx_req !== 1) begin bad++; $display("FAIL single_req got=%b want=1", uart_tx_req); end
      if (uart_tx_data !== 8'h41) begin bad++; $display("FAIL single_data got=%h want=41", uart_tx_data); end
      if (tx_owner !== 0) begin bad++; $display("FAIL single_owner got=%b want=0", tx_owner); end
      tt_tx_data = 8'hFF;
      wait_tt_ack(ok);
      total += 3;
      if (!ok) begin bad++; $display("FAIL single_ack_timeout got=0 want=1"); end
      if (mon_tx_ack !== 0) begin bad++; $display("FAIL single_mon_ack got=%b want=0", mon_tx_ack); end
      if (mon_tx_empty !== 0) begin bad++; $display("FAIL single_mon_empty got=%b want=0", mon_tx_empty); end
      tt_tx_req = 0;
      repeat (3) @(negedge clk);
      total += 3;
      if (tt_tx_ack !== 0) begin bad++; $display("FAIL single_ack_fall got=%b want=0", tt_tx_ack); end
      if (tx_busy !== 1 || mon_tx_empty !== 0) begin bad++; $display("FAIL single_drain busy=%b mon_empty=%b want=1/0", tx_busy, mon_tx_empty); end
      if (uart_tx_data !== 8'h41) begin bad++; $display("FAIL single_data_hold got=%h want=41", uart_tx_data); end
      wait_idle(ok);
      total += 2;
      if (!ok) begin bad++; $display("FAIL single_idle_timeout got=0 want=1"); end
      if (mon_tx_empty !== 1 || tt_tx_empty !== 1) begin bad++; $display("FAIL single_idle_empty got=%b%b want=11", tt_tx_empty, mon_tx_empty); end
   endtask

   task automatic test_tie();
      bit ok;
      test_reset();
      tt_tx_data  = 8'h41;
      mon_tx_data = 8'h5A;
      tt_tx_req   = 1;
      mon_tx_req  = 1;
      wait_req(ok);
      total += 2;
      if (!ok) begin bad++; $display("FAIL tie_first_timeout got=0 want=1"); end
      if (uart_tx_data !== 8'h41 || tx_owner !== 0) begin bad++; $display("FAIL tie_first got=%h/%b want=41/0", uart_tx_data, tx_owner); end
      tt_tx_req = 0;
      wait_idle(ok);
      wait_req(ok);
      total += 2;
      if (!ok) begin bad++; $display("FAIL tie_second_timeout got=0 want=1"); end
      if (uart_tx_data !== 8'h5A || tx_owner !== 1) begin bad++; $display("FAIL tie_second got=%h/%b want=5A/1", uart_tx_data, tx_owner); end
      mon_tx_req = 0;
      wait_idle(ok);
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic want;
      tt_tx_req  = 1;
      mon_tx_req = 1;
      wait_req(ok);
      for (int i = 0; i < 6; i++) begin
         want = i[0];
         total += 2;
         if (!ok) begin bad++; $display("FAIL b2b_req%0d got=0 want=1", i); end
         if (tx_owner !== want || uart_tx_data !== (want ? 8'h5A : 8'h41))
            begin bad++; $display("FAIL b2b_grant%0d got=%b/%h want=%b/%h", i, tx_owner, uart_tx_data, want, want ? 8'h5A : 8'h41); end
         if (i == 5) begin tt_tx_req = 0; mon_tx_req = 0; end
         ok = 0;
         for (int j = 0; j < 200 && !ok; j++) begin
            @(negedge clk);
            ok = !tx_busy;
         end
         if (i < 5) begin
            @(negedge clk);
            ok = uart_tx_req;
         end
      end
      wait_idle(ok);
   endtask

   task automatic test_rx_nonowner();
      mon_rx_req    = 1;
      uart_rx_data  = 8'h0D;
      uart_rx_empty = 0;
      uart_rx_ack   = 1;
      @(negedge clk);
      total += 4;
      if (uart_rx_req !== 0) begin bad++; $display("FAIL rx_nonowner_req got=%b want=0", uart_rx_req); end
      if (mon_rx_empty !== 1 || mon_rx_ack !== 0) begin bad++; $display("FAIL rx_nonowner_view empty=%b ack=%b want=1/0", mon_rx_empty, mon_rx_ack); end
      if (mon_rx_data !== 8'h00) begin bad++; $display("FAIL rx_nonowner_data got=%h want=00", mon_rx_data); end
      if (tt_rx_data !== 8'h0D || tt_rx_empty !== 0) begin bad++; $display("FAIL rx_owner_view got=%h/%b want=0D/0", tt_rx_data, tt_rx_empty); end
      mon_rx_req  = 0;
      uart_rx_ack = 0;
      uart_rx_empty = 1;
      @(negedge clk);
   endtask

   task automatic test_rx_switch();
      tt_rx_req     = 1;
      uart_rx_data  = 8'h55;
      uart_rx_empty = 0;
      @(negedge clk);
      total += 1;
      if (uart_rx_req !== 1) begin bad++; $display("FAIL rxsw_req got=%b want=1", uart_rx_req); end
      rx_sel = 1;
      @(negedge clk);
      total += 1;
      if (rx_owner !== 0 || uart_rx_req !== 1) begin bad++; $display("FAIL rxsw_defer owner=%b req=%b want=0/1", rx_owner, uart_rx_req); end
      uart_rx_ack = 1;
      @(negedge clk);
      total += 1;
      if (tt_rx_ack !== 1 || tt_rx_data !== 8'h55) begin bad++; $display("FAIL rxsw_data ack=%b data=%h want=1/55", tt_rx_ack, tt_rx_data); end
      tt_rx_req = 0;
      @(negedge clk);
      total += 1;
      if (rx_owner !== 0) begin bad++; $display("FAIL rxsw_hold_ack got=%b want=0", rx_owner); end
      uart_rx_ack   = 0;
      uart_rx_empty = 1;
      @(negedge clk);
      total += 1;
      if (rx_owner !== 0 || uart_rx_req !== 0) begin bad++; $display("FAIL rxsw_idle owner=%b req=%b want=0/0", rx_owner, uart_rx_req); end
      @(negedge clk);
      total += 1;
      if (rx_owner !== 1) begin bad++; $display("FAIL rxsw_owner got=%b want=1", rx_owner); end
      uart_rx_data = 8'h33;
      @(negedge clk);
      total += 1;
      if (mon_rx_data !== 8'h33 || tt_rx_data !== 8'h00) begin bad++; $display("FAIL rxsw_route mon=%h tt=%h want=33/00", mon_rx_data, tt_rx_data); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      tt_tx_data = 8'h41;
      tt_tx_req  = 1;
      wait_req(ok);
      tt_tx_req = 0;
      wait_idle(ok);
      mon_tx_data = 8'h5A;
      mon_tx_req  = 1;
      mon_rx_req  = 1;
      wait_req(ok);
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = mon_tx_ack;
      end
      mon_tx_req = 0;
      @(negedge clk);
      total += 2;
      if (tx_busy !== 1 || uart_tx_req !== 0 || tx_owner !== 1) begin bad++; $display("FAIL rst_in_ack busy=%b req=%b owner=%b want=1/0/1", tx_busy, uart_tx_req, tx_owner); end
      if (uart_rx_req !== 1) begin bad++; $display("FAIL rst_rx_active got=%b want=1", uart_rx_req); end
      reset = 1;
      @(negedge clk);
      total += 2;
      if (uart_tx_req !== 0 || tx_busy !== 0 || tx_owner !== 0) begin bad++; $display("FAIL rst_mid req=%b busy=%b owner=%b want=0/0/0", uart_tx_req, tx_busy, tx_owner); end
      if (uart_rx_req !== 0 || rx_owner !== 0) begin bad++; $display("FAIL rst_mid_rx req=%b owner=%b want=0/0", uart_rx_req, rx_owner); end
      reset = 0;
      mon_rx_req = 0;
      wait_idle(ok);
      tt_tx_req  = 1;
      mon_tx_req = 1;
      wait_req(ok);
      total += 1;
      if (!ok || tx_owner !== 0 || uart_tx_data !== 8'h41) begin bad++; $display("FAIL rst_tie got=%b/%h want=0/41", tx_owner, uart_tx_data); end
      tt_tx_req  = 0;
      mon_tx_req = 0;
      wait_idle(ok);
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_single();
      test_tie();
      test_back_to_back();
      test_rx_nonowner();
      test_rx_switch();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
